axis_packet_arbiter: RTL and testbench
======================================

Name: axis_packet_arbiter

Overview:
- Shares one axi_stream master port between N_INPUTS axi_stream slave requesters.
- Arbitration is round-robin and packet-aware: a grant is held until the tlast beat has been accepted.
- Sits in front of register_slice-based stream pipelines, for example to merge several ADC/processing channels onto one DMA stream.
- The output is registered; a watchdog releases a grant held by a requester that stalls mid-packet.

Parameters:
- DATA_WIDTH, 32, data field width of all streams.
- DEST_WIDTH, 32, dest field width.
- USER_WIDTH, 32, user field width.
- N_INPUTS, 4, number of requesters (2..16).
- PACKET_MODE, 1, 1 = hold grant until tlast; 0 = re-arbitrate after every beat.
- TAG_DEST, 0, 1 = replace out.dest with the granted input index (zero-extended); 0 = pass in.dest through.
- TIMEOUT, 1024, stall cycles before a forced grant release; 0 disables the watchdog.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  axi_stream.slave  array [N_INPUTS]  requester streams (data, dest, user, tlast, valid, ready).
- out  axi_stream.master  1 interface  arbitrated output stream.
- enable_mask  input  N_INPUTS  per-input arbitration enable; a masked input is never newly granted.
- grant_idx  output  $clog2(N_INPUTS)  index of the current or most recent grant.
- grant_active  output  1  high while state is GRANTED.
- timeout_pulse  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (reset=1 at a clock edge):
  - state=IDLE.
  - out.valid=0; out.data, out.dest, out.user and out.tlast all 0.
  - grant_idx=N_INPUTS-1, so the first grant search starts at input 0.
  - grant_active=0, timeout_pulse=0, watchdog counter=0, all in[i].ready=0.
  - Reset mid-packet drops the packet in flight without completing it.
- FSM states: IDLE, GRANTED.
- IDLE:
  - req[i] = in[i].valid & enable_mask[i].
  - If any req is set: choose the first set index scanning grant_idx+1, grant_idx+2, … with wrap modulo N_INPUTS.
  - Register the chosen index into grant_idx and go to GRANTED next cycle.
  - No ready is asserted while in IDLE, so arbitration costs a 1-cycle bubble per packet.
  - If no req is set: stay in IDLE and keep grant_idx.
- GRANTED:
  - in[grant_idx].ready = ~out.valid | out.ready. This is combinational; all other in[j].ready=0.
  - On an accepted beat (in[g].valid & in[g].ready), load data, user and tlast into the output register and set out.valid=1.
  - out.dest on that load is g when TAG_DEST=1, else in[g].dest.
  - If out.ready=1 and no new beat is loaded, clear out.valid.
  - Latency is 1 cycle from input acceptance to out.valid.
  - Full throughput: one beat per cycle while out.ready=1.
  - Release to IDLE on an accepted beat with tlast=1 (PACKET_MODE=1), or on any accepted beat (PACKET_MODE=0). grant_idx is kept, which drives the round-robin pointer.
- Out-register backpressure: while out.valid=1 and out.ready=0, the output register holds its contents stable (AXI-Stream rule) and in[g].ready=0.
- enable_mask deasserted for the granted input mid-packet has no effect until release; the packet completes.
- Watchdog (TIMEOUT>0):
  - The counter increments each GRANTED cycle with in[g].valid=0.
  - It clears on any accepted beat and on entry to GRANTED.
  - When the counter reaches TIMEOUT-1 with valid still low: go to IDLE, pulse timeout_pulse for 1 cycle, and reset the counter.
  - No synthetic tlast is emitted; downstream sees a truncated packet.
  - Cycles where out.ready=0 do not count, since the stall is downstream.
- Simultaneous events:
  - A release and a new request in the same cycle: the new grant is decided in the following IDLE cycle, never in the same cycle.
  - A timeout and an accepted beat in the same cycle: the accepted beat wins and the counter clears.
- grant_active = (state==GRANTED).

Test Plan:
1. Reset, then in0 and in2 each send a 3-beat packet (data 0x10..0x12 and 0x20..0x22), out.ready=1 → out shows 0x10,0x11,0x12(tlast), one bubble, then 0x20,0x21,0x22(tlast); grant_idx sequence 0 then 2.
2. All 4 inputs continuously valid with 1-beat packets, PACKET_MODE=1 → grant order 0,1,2,3,0,1; each input gets exactly 25% of output beats over 40 cycles.
3. in1 sends 4 beats while out.ready toggles 1,0,0,1,… → no beat lost or duplicated; out.data stays stable while out.ready=0; in1.ready=0 during the stall.
4. TAG_DEST=1, in3 sends one beat with dest=0x55 → out.dest=3.
5. enable_mask=4'b1011 with all inputs valid → input 2 is never granted; clearing the mask bit while input 2 is granted mid-packet still delivers its full packet.
6. TIMEOUT=8: in0 sends 1 beat without tlast, then drops valid → timeout_pulse high for exactly 1 cycle, 8 cycles after the last accepted beat; the FSM returns to IDLE and in1's pending packet is granted next.

Source files
------------

// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle shared by every requester and by the arbitrated output.
// The master drives payload and valid, and the slave returns ready.
interface axi_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 32,
    parameter int USER_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  tlast;
    logic                  valid;
    logic                  ready;

    modport master (output data, dest, user, tlast, valid, input ready);
    modport slave  (input data, dest, user, tlast, valid, output ready);
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-aware round-robin arbiter that merges N_INPUTS AXI-Stream requesters onto one
// registered output stream. A watchdog drops a grant whose owner stalls mid-packet.
module axis_packet_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEST_WIDTH  = 32,
    parameter int USER_WIDTH  = 32,
    parameter int N_INPUTS    = 4,
    parameter int PACKET_MODE = 1,
    parameter int TAG_DEST    = 0,
    parameter int TIMEOUT     = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    axi_stream.slave                    in [N_INPUTS],
    axi_stream.master                   out,
    input  logic [N_INPUTS-1:0]         enable_mask,
    output logic [$clog2(N_INPUTS)-1:0] grant_idx,
    output logic                        grant_active,
    output logic                        timeout_pulse
);
    localparam int GW  = $clog2(N_INPUTS);
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, GRANTED} state_t;

    logic [N_INPUTS-1:0]   in_valid, in_last, in_ready, req;
    logic [DATA_WIDTH-1:0] in_data [N_INPUTS];
    logic [DEST_WIDTH-1:0] in_dest [N_INPUTS];
    logic [USER_WIDTH-1:0] in_user [N_INPUTS];

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_in
        assign in_valid[i] = in[i].valid;
        assign in_last[i]  = in[i].tlast;
        assign in_data[i]  = in[i].data;
        assign in_dest[i]  = in[i].dest;
        assign in_user[i]  = in[i].user;
        assign in[i].ready = in_ready[i];
    end

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DEST_WIDTH-1:0] out_dest_q, out_dest_d;
    logic [USER_WIDTH-1:0] out_user_q, out_user_d;
    logic                  out_last_q, out_last_d;
    logic [WDW-1:0]        wd_q, wd_d;
    logic                  timeout_q, timeout_d;

    logic                  sel_valid, sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DEST_WIDTH-1:0] sel_dest;
    logic [USER_WIDTH-1:0] sel_user;
    logic [GW-1:0]         pick, pick_hi, pick_lo;
    logic                  found_hi, beat_ready, accept;

    assign req = in_valid & enable_mask;

    // Mux the currently granted requester onto the shared datapath.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_dest  = '0;
        sel_user  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (GW'(i) == grant_q) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i];
                sel_dest  = in_dest[i];
                sel_user  = in_user[i];
            end
        end
    end

    // Round-robin: the lowest requester above the last grant, else the lowest one at or below it.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(grant_q)) begin
                    pick_hi  = GW'(i);
                    found_hi = 1'b1;
                end else begin
                    pick_lo = GW'(i);
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    assign beat_ready = ~out_valid_q | out.ready;
    assign accept     = (state_q == GRANTED) & sel_valid & beat_ready;

    always_comb begin
        in_ready = '0;
        if (state_q == GRANTED) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (GW'(i) == grant_q) in_ready[i] = beat_ready;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_dest_d  = out_dest_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        wd_d        = wd_q;
        timeout_d   = 1'b0;

        // The output register drains whenever downstream takes it, even while idle.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_dest_d  = (TAG_DEST != 0) ? DEST_WIDTH'(grant_q) : sel_dest;
            out_user_d  = sel_user;
            out_last_d  = sel_last;
        end else if (out.ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    state_d = GRANTED;
                    wd_d    = '0;
                end
            end
            GRANTED: begin
                if (accept) begin
                    wd_d = '0;
                    if (PACKET_MODE == 0 || sel_last) state_d = IDLE;
                end else if (TIMEOUT > 0 && !sel_valid && out.ready) begin
                    // Only upstream starvation counts; downstream backpressure is not a stall.
                    if (wd_q == WD_LAST) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        wd_d      = '0;
                    end else begin
                        wd_d = wd_q + WDW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= GW'(N_INPUTS - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= '0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_dest_q  <= out_dest_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
        end
    end

    assign out.valid     = out_valid_q;
    assign out.data      = out_data_q;
    assign out.dest      = out_dest_q;
    assign out.user      = out_user_q;
    assign out.tlast     = out_last_q;
    assign grant_idx     = grant_q;
    assign grant_active  = (state_q == GRANTED);
    assign timeout_pulse = timeout_q;
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomized bench for axis_packet_arbiter with a cycle-level behavioural model, plus a
// second instance (tagged dest, per-beat arbitration) exercised with directed traffic.
module tb_axis_packet_arbiter;
    localparam int N = 4, W = 32, PM = 1, TAG = 0, TMO = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] dest;
        logic [31:0] user;
        logic        last;
    } beat_t;

    // ---------------- instance A: PACKET_MODE=1, TAG_DEST=0, TIMEOUT=8
    beat_t       q [N][$];
    logic [N-1:0] a_vld = '0, a_last = '0, a_rdy, acc = '0, mask = '1;
    logic [31:0] a_data [N], a_dest [N], a_user [N];
    logic        o_rdy = 1'b1;
    logic [1:0]  gidx;
    logic        gact, tpulse;
    axi_stream #(.DATA_WIDTH(W), .DEST_WIDTH(W), .USER_WIDTH(W)) ain [N] ();
    axi_stream #(.DATA_WIDTH(W), .DEST_WIDTH(W), .USER_WIDTH(W)) aout ();

    // ---------------- instance B: PACKET_MODE=0, TAG_DEST=1, no watchdog
    beat_t       bq [N][$];
    logic [N-1:0] b_vld = '0, b_last = '0, b_rdy, b_acc = '0;
    logic [31:0] b_data [N], b_dest [N], b_user [N];
    logic [1:0]  b_gidx;
    logic        b_gact, b_tp;
    axi_stream #(.DATA_WIDTH(W), .DEST_WIDTH(W), .USER_WIDTH(W)) bin [N] ();
    axi_stream #(.DATA_WIDTH(W), .DEST_WIDTH(W), .USER_WIDTH(W)) bout ();

    for (genvar i = 0; i < N; i++) begin : g_conn
        assign ain[i].valid = a_vld[i];
        assign ain[i].tlast = a_last[i];
        assign ain[i].data  = a_data[i];
        assign ain[i].dest  = a_dest[i];
        assign ain[i].user  = a_user[i];
        assign a_rdy[i]     = ain[i].ready;
        assign bin[i].valid = b_vld[i];
        assign bin[i].tlast = b_last[i];
        assign bin[i].data  = b_data[i];
        assign bin[i].dest  = b_dest[i];
        assign bin[i].user  = b_user[i];
        assign b_rdy[i]     = bin[i].ready;
    end
    assign aout.ready = o_rdy;
    assign bout.ready = 1'b1;

    axis_packet_arbiter #(.DATA_WIDTH(W), .DEST_WIDTH(W), .USER_WIDTH(W), .N_INPUTS(N),
                          .PACKET_MODE(PM), .TAG_DEST(TAG), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .in(ain), .out(aout), .enable_mask(mask),
        .grant_idx(gidx), .grant_active(gact), .timeout_pulse(tpulse));

    axis_packet_arbiter #(.DATA_WIDTH(W), .DEST_WIDTH(W), .USER_WIDTH(W), .N_INPUTS(N),
                          .PACKET_MODE(0), .TAG_DEST(1), .TIMEOUT(0)) dut_b (
        .clock(clock), .reset(reset), .in(bin), .out(bout), .enable_mask(4'b1111),
        .grant_idx(b_gidx), .grant_active(b_gact), .timeout_pulse(b_tp));

    int total = 0, bad = 0, cyc = 0, pat = 0, o_mode = 0;
    int pval [N];
    bit chk_en = 1'b0, gact_prev = 1'b0;
    logic [31:0] olog [$], blog [$], bdest [$], buser [$];
    bit olast [$], blast [$];
    int ocyc [$], tlog [$], glog [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance A
    int m_owner, m_ptr, m_wd;   // m_owner = -1 when no requester holds the port
    bit m_ov, m_ol, m_to;
    logic [31:0] m_od, m_odest, m_ou;

    task automatic model_reset();
        m_owner = -1; m_ptr = N - 1; m_wd = 0;
        m_ov = 0; m_ol = 0; m_to = 0; m_od = 0; m_odest = 0; m_ou = 0;
    endtask

    task automatic model_step();
        int g, j;
        bit take;
        if (reset) begin
            model_reset();
            return;
        end
        m_to = 0;
        if (m_owner < 0) begin
            if (o_rdy) m_ov = 0;
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (a_vld[j] && mask[j]) begin
                    m_owner = j; m_ptr = j; m_wd = 0;
                    break;
                end
            end
        end else begin
            g = m_owner;
            take = a_vld[g] && (!m_ov || o_rdy);
            if (take) begin
                m_ov = 1; m_od = a_data[g]; m_ou = a_user[g]; m_ol = a_last[g];
                m_odest = (TAG != 0) ? 32'(g) : a_dest[g];
                m_wd = 0;
                if (a_last[g] || PM == 0) m_owner = -1;
            end else begin
                if (o_rdy) m_ov = 0;
                if (TMO > 0 && !a_vld[g] && o_rdy) begin
                    if (m_wd == TMO - 1) begin
                        m_owner = -1; m_to = 1; m_wd = 0;
                    end else begin
                        m_wd++;
                    end
                end
            end
        end
    endtask

    // Compare on the falling edge, log handshakes, then advance the model.
    always @(negedge clock) begin
        logic [N-1:0] exp_rdy;
        if (chk_en) begin
            chk("out_valid", aout.valid, m_ov);
            if (m_ov) begin
                chk("out_data", aout.data, m_od);
                chk("out_dest", aout.dest, m_odest);
                chk("out_user", aout.user, m_ou);
                chk("out_tlast", aout.tlast, m_ol);
            end
            chk("grant_idx", gidx, m_ptr);
            chk("grant_active", gact, m_owner >= 0);
            chk("timeout_pulse", tpulse, m_to);
            exp_rdy = '0;
            if (m_owner >= 0 && (!m_ov || o_rdy)) exp_rdy[m_owner] = 1'b1;
            chk("in_ready", a_rdy, exp_rdy);
            if (aout.valid && o_rdy) begin
                olog.push_back(aout.data); olast.push_back(aout.tlast); ocyc.push_back(cyc);
            end
            if (tpulse === 1'b1) tlog.push_back(cyc);
            if (gact === 1'b1 && !gact_prev) glog.push_back(int'(gidx));
            gact_prev = (gact === 1'b1);
            if (bout.valid === 1'b1) begin
                blog.push_back(bout.data); bdest.push_back(bout.dest);
                buser.push_back(bout.user); blast.push_back(bout.tlast);
            end
        end
        acc   = a_vld & a_rdy;
        b_acc = b_vld & b_rdy;
        model_step();
        cyc++;
    end

    // Sources: a presented beat is held until taken; new beats appear with probability pval.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
            if (q[i].size() == 0) a_vld[i] = 1'b0;
            else if (!(a_vld[i] && !acc[i])) a_vld[i] = ($urandom_range(99) < pval[i]);
            if (q[i].size() > 0) begin
                a_data[i] = q[i][0].data; a_dest[i] = q[i][0].dest;
                a_user[i] = q[i][0].user; a_last[i] = q[i][0].last;
            end else begin
                a_data[i] = '0; a_dest[i] = '0; a_user[i] = '0; a_last[i] = 1'b0;
            end
            if (b_acc[i] && bq[i].size() > 0) void'(bq[i].pop_front());
            b_vld[i] = (bq[i].size() > 0);
            if (bq[i].size() > 0) begin
                b_data[i] = bq[i][0].data; b_dest[i] = bq[i][0].dest;
                b_user[i] = bq[i][0].user; b_last[i] = bq[i][0].last;
            end else begin
                b_data[i] = '0; b_dest[i] = '0; b_user[i] = '0; b_last[i] = 1'b0;
            end
        end
        case (o_mode)
            1:       o_rdy = ($urandom_range(99) < 70);
            2:       o_rdy = (pat % 3 == 0);
            default: o_rdy = 1'b1;
        endcase
        pat++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic push_pkt(input int i, input int len, input logic [31:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + 32'(k); b.dest = $urandom; b.user = $urandom; b.last = (k == len - 1);
            q[i].push_back(b);
        end
    endtask

    task automatic wait_beats(input int n, input int limit);
        int c = 0;
        while (olog.size() < n && c < limit) begin
            tick(1); c++;
        end
        chk("beats_arrived", olog.size() >= n, 1);
    endtask

    task automatic drain(input int limit);
        int c = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || aout.valid) && c < limit) begin
            tick(1); c++;
        end
        chk("drained", c < limit, 1);
    endtask

    task automatic clear_logs();
        olog.delete(); olast.delete(); ocyc.delete(); tlog.delete(); glog.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        clear_logs();
    endtask

    int e1 [6] = '{'h10, 'h11, 'h12, 'h20, 'h21, 'h22};
    int e_b [4] = '{'hA0, 'hB0, 'hD0, 'hA1};
    int e_bd [4] = '{0, 1, 3, 0};
    int e_g2 [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        int cnt [N];
        int n2, c;
        beat_t b;
        model_reset();
        for (int i = 0; i < N; i++) pval[i] = 100;
        repeat (2) @(posedge clock);
        #2;
        chk_en = 1'b1;
        chk("rst_out_valid", aout.valid, 0);
        chk("rst_out_data", aout.data, 0);
        chk("rst_grant_idx", gidx, 3);
        chk("rst_grant_active", gact, 0);
        chk("rst_timeout", tpulse, 0);
        chk("rst_ready", a_rdy, 0);
        reset = 1'b0;

        // Instance B: tagged dest, re-arbitration after every beat.
        b = '{data: 32'hA0, dest: 32'h11, user: 32'h0, last: 1'b0}; bq[0].push_back(b);
        b = '{data: 32'hA1, dest: 32'h11, user: 32'h0, last: 1'b1}; bq[0].push_back(b);
        b = '{data: 32'hB0, dest: 32'h22, user: 32'h0, last: 1'b1}; bq[1].push_back(b);
        b = '{data: 32'hD0, dest: 32'h55, user: 32'h77, last: 1'b0}; bq[3].push_back(b);
        c = 0;
        while (blog.size() < 4 && c < 40) begin
            tick(1); c++;
        end
        chk("b_beats_arrived", blog.size() >= 4, 1);
        tick(3);
        for (int k = 0; k < 4 && k < blog.size(); k++) begin
            chk($sformatf("b_data[%0d]", k), blog[k], e_b[k]);
            chk($sformatf("b_dest[%0d]", k), bdest[k], e_bd[k]);
        end
        if (blog.size() >= 4) begin
            chk("b_user_in3", buser[2], 32'h77);
            chk("b_tlast_last", blast[3], 1);
        end
        chk("b_grant_idx_final", b_gidx, 0);
        chk("b_grant_active_final", b_gact, 0);
        chk("b_no_timeout", b_tp, 0);

        // Two 3-beat packets from in0 and in2 with one arbitration bubble between them.
        clear_logs();
        push_pkt(0, 3, 32'h10);
        push_pkt(2, 3, 32'h20);
        wait_beats(6, 50);
        if (olog.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("t1_data[%0d]", k), olog[k], e1[k]);
                chk($sformatf("t1_last[%0d]", k), olast[k], (k == 2 || k == 5));
            end
            chk("t1_back_to_back", ocyc[2] - ocyc[0], 2);
            chk("t1_bubble", ocyc[3] - ocyc[2], 2);
        end
        chk("t1_grants", glog.size() >= 2 ? {glog[0], glog[1]} : 64'hFFFF, {32'd0, 32'd2});
        drain(50);

        // Four busy requesters with single-beat packets share the port equally.
        pulse_reset();
        for (int k = 0; k < 10; k++)
            for (int i = 0; i < N; i++) push_pkt(i, 1, 32'((i << 8) | k));
        wait_beats(20, 120);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 0; k < 20 && k < olog.size(); k++) cnt[olog[k][11:8]]++;
        for (int i = 0; i < N; i++) chk($sformatf("t2_share[%0d]", i), cnt[i], 5);
        for (int k = 0; k < 6; k++)
            chk($sformatf("t2_order[%0d]", k), k < glog.size() ? glog[k] : -1, e_g2[k]);
        drain(200);

        // Backpressure pattern 1,0,0 on a 4-beat packet.
        clear_logs();
        o_mode = 2;
        push_pkt(1, 4, 32'h30);
        wait_beats(4, 60);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t3_data[%0d]", k), k < olog.size() ? olog[k] : 0, 32'h30 + 32'(k));
        tick(6);
        chk("t3_no_duplicate", olog.size(), 4);
        o_mode = 0;
        drain(60);

        // Masked input is skipped; masking it mid-packet still delivers the whole packet.
        clear_logs();
        mask = 4'b1011;
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 3; p++) push_pkt(i, 2, 32'((i << 8) | (p << 4)));
        tick(40);
        n2 = 0;
        foreach (glog[k]) if (glog[k] == 2) n2++;
        chk("t5_masked_never_granted", n2, 0);
        mask = 4'b1111;
        c = 0;
        while (!(gact === 1'b1 && gidx == 2) && c < 60) begin
            tick(1); c++;
        end
        chk("t5_in2_granted", c < 60, 1);
        mask = 4'b1011;
        tick(10);
        n2 = 0;
        foreach (olog[k]) if (olog[k][11:8] == 2) n2++;
        chk("t5_in2_beats", n2, 2);
        chk("t5_in2_tlast", olog.size() > 0 ? olast[olog.size() - 1] : 0, 1);
        mask = 4'b1111;
        drain(300);

        // Watchdog: in0 stalls after a beat without tlast, in1 waits behind it.
        pulse_reset();
        b = '{data: 32'h40, dest: 32'h0, user: 32'h0, last: 1'b0}; q[0].push_back(b);
        push_pkt(1, 2, 32'h50);
        wait_beats(3, 60);
        tick(3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t6_data[%0d]", k), k < olog.size() ? olog[k] : 0,
                k == 0 ? 32'h40 : 32'h50 + 32'(k - 1));
        chk("t6_pulse_width", tlog.size(), 1);
        chk("t6_pulse_delay", (tlog.size() > 0 && ocyc.size() > 0) ? tlog[0] - ocyc[0] : -1, 8);
        chk("t6_grants", glog.size() >= 2 ? {glog[0], glog[1]} : 64'hFFFF, {32'd0, 32'd1});

        // Random traffic, backpressure, masks, stalls and occasional resets.
        o_mode = 1;
        for (int t = 0; t < 3000; t++) begin
            tick(1);
            reset = ($urandom_range(299) == 0);
            if (t % 25 == 0) begin
                mask = 4'($urandom);
                for (int i = 0; i < N; i++)
                    case ($urandom_range(3))
                        0: pval[i] = 5;
                        1: pval[i] = 40;
                        2: pval[i] = 80;
                        default: pval[i] = 100;
                    endcase
            end
            for (int i = 0; i < N; i++)
                if (q[i].size() < 4 && $urandom_range(9) == 0)
                    push_pkt(i, $urandom_range(1, 5), $urandom);
        end
        reset = 1'b0;
        mask = 4'b1111;
        o_mode = 0;
        for (int i = 0; i < N; i++) pval[i] = 100;
        drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL global_time_limit: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
